imem_loader: RTL and testbench
==============================

# imem_loader

Writer-side companion to the byte-addressed, big-endian instruction memory. Accepts a program as a valid/ready byte stream, packs every four bytes MSB-first into a word, and writes each word into instruction memory through its address, RW and write-data lines while holding the CPU off the memory. Sits between the boot/debug byte source and the instruction memory port, muxed ahead of the PC-driven fetch address.

## Interface
- DEPTH_BYTES, 256: instruction memory size in bytes; must be a multiple of 4.
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; samples BaseAddr and LoadWords and begins a load.
- BaseAddr  in  32  byte address of the first word.
- LoadWords  in  8  number of 32-bit words to load; 0 is legal.
- ByteIn  in  8  stream byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts ByteIn this cycle.
- IAddr  out  32  memory byte address.
- InsMemRW  out  1  1 = read, 0 = write; memory RW control.
- DataIn  out  32  packed write word, {b0,b1,b2,b3}.
- Busy  out  1  load in progress.
- CpuHold  out  1  CPU must stall fetch; equals Busy.
- Done  out  1  sticky: last load completed cleanly.
- Error  out  1  sticky: last load rejected or failed.

## Operation
- States: IDLE, COLLECT, WRITE, FINISH (plus CHECK when the checksum feature is enabled).
- IDLE: ByteReady=0, InsMemRW=1. On Start: clear Done/Error, latch BaseAddr into address register, LoadWords into word counter, clear byte index.
  - BaseAddr[1:0]!=0 or BaseAddr+4*LoadWords > DEPTH_BYTES: Error=1, stay IDLE, no write issued.
  - LoadWords==0: go to FINISH.
  - Otherwise go to COLLECT.
- COLLECT: ByteReady=1. A byte transfers on a rising edge with ByteValid&&ByteReady. Byte k (k=0..3) goes into DataIn bits [31-8k -: 8]. After the 4th transfer, go to WRITE.
- WRITE: for exactly one cycle, ByteReady=0, InsMemRW=0, IAddr=current word address, DataIn stable. The next edge adds 4 to the address and decrements the counter. If the counter reaches 0, go to FINISH; else go to COLLECT with InsMemRW=1.
- FINISH: Done=1 and return to IDLE. IAddr holds the last written address.
- Start while Busy is ignored.
- ByteValid outside COLLECT/CHECK is ignored; no byte is consumed.
- Address arithmetic is 32-bit unsigned. The overflow check uses a 33-bit sum, so wrap-around is detected, not permitted.

## Timing
- Reset values: IAddr=0, InsMemRW=1, DataIn=0, ByteReady=0, Busy=0, CpuHold=0, Done=0, Error=0, state IDLE.
- Busy/CpuHold rise the cycle after an accepted Start and fall the cycle FINISH is left.
- Minimum latency per word is 5 cycles: 4 byte-accept cycles plus 1 WRITE cycle.
- Minimum load time is 5·N + 2 cycles from Start to Done.
- InsMemRW=0 and a new IAddr change on the same edge. InsMemRW never stays 0 for more than one cycle.
- Reset asserted mid-load aborts immediately: all outputs return to reset values and the partially packed word is discarded.
- A word already written stays written.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE (or immediately, for LoadWords==0), enter CHECK with ByteReady=1 and accept one checksum byte.
  - The 8-bit sum of all data bytes plus the checksum byte, mod 256, must be 0. If so, Done=1; otherwise Error=1 and Done=0.
  - Memory contents are not rolled back.
- Undefined: no CHECK state, no checksum byte consumed, no accumulator logic.

## Test plan
- Reset, then Start with BaseAddr=0, LoadWords=2, bytes 12 34 56 78 9A BC DE F0 streamed back-to-back -> two single-cycle writes: IAddr=0 with DataIn=0x12345678, then IAddr=4 with DataIn=0x9ABCDEF0; Done=1 at cycle 12; memory readback matches.
- Same load with ByteValid toggled every other cycle -> identical writes, no extra or lost bytes, InsMemRW=0 exactly twice.
- Start with BaseAddr=0x02 -> Error=1, no InsMemRW=0 ever; repeat with BaseAddr=0xFC, LoadWords=2 -> Error=1, no writes.
- Reset deasserted-then-asserted after the 2nd byte of word 1 of a 3-word load -> outputs return to reset values at once; word 0 remains in memory; next Start loads normally.
- LoadWords=0 -> Done=1 two cycles after Start, no writes; Start pulsed during Busy -> ignored, counter unaffected.
- With IMEM_LOADER_CHECKSUM_EN: bytes 01 02 03 04 then checksum F6 -> Done=1; checksum F7 -> Error=1, word 0x01020304 still at BaseAddr.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader that packs big-endian words and writes them into instruction memory.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned DEPTH_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [7:0]  load_words,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] iaddr,
    output logic        ins_mem_rw,
    output logic [31:0] data_in,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FINISH
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t          state;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   words_q;
    logic [1:0]      idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]      sum_q;
    logic            sum_ok_q;
`endif

    // 33-bit end address so a wrapping load is rejected rather than allowed
    logic [AW:0]     end_addr_c;
    logic            start_bad_c;
    logic            xfer_c;

    assign end_addr_c  = {1'b0, base_addr} + {23'b0, load_words, 2'b00};
    assign start_bad_c = (base_addr[1:0] != 2'b00) || (end_addr_c > (AW+1)'(DEPTH_BYTES));
    assign xfer_c      = byte_valid && byte_ready;
    assign cpu_hold    = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            words_q    <= '0;
            idx_q      <= '0;
            iaddr      <= '0;
            ins_mem_rw <= 1'b1;
            data_in    <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            sum_ok_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done    <= 1'b0;
                        error   <= 1'b0;
                        addr_q  <= base_addr;
                        words_q <= load_words;
                        idx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                        if (start_bad_c) begin
                            error <= 1'b1;
                        end else if (load_words == '0) begin
                            busy <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            byte_ready <= 1'b1;
                            state      <= S_CHECK;
`else
                            state      <= S_FINISH;
`endif
                        end else begin
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            state      <= S_COLLECT;
                        end
                    end
                end

                // Byte k lands MSB-first; the 4th byte launches the write cycle
                S_COLLECT: begin
                    if (xfer_c) begin
                        case (idx_q)
                            2'd0:    data_in[31:24] <= byte_in;
                            2'd1:    data_in[23:16] <= byte_in;
                            2'd2:    data_in[15:8]  <= byte_in;
                            default: data_in[7:0]   <= byte_in;
                        endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_q <= sum_q + byte_in;
`endif
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            byte_ready <= 1'b0;
                            ins_mem_rw <= 1'b0;
                            iaddr      <= addr_q;
                            state      <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    ins_mem_rw <= 1'b1;
                    addr_q     <= addr_q + 32'd4;
                    words_q    <= words_q - 8'd1;
                    if (words_q == 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        byte_ready <= 1'b1;
                        state      <= S_CHECK;
`else
                        state      <= S_FINISH;
`endif
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= S_COLLECT;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer_c) begin
                        sum_ok_q   <= (8'(sum_q + byte_in) == 8'h00);
                        byte_ready <= 1'b0;
                        state      <= S_FINISH;
                    end
                end
`endif

                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    done  <= sum_ok_q;
                    error <= !sum_ok_q;
`else
                    done  <= 1'b1;
`endif
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a load-level model predicts every write, a per-cycle
// compare process checks them, and literal expectations pin timing and memory contents.
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [7:0]  load_words = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] iaddr;
    logic        ins_mem_rw;
    logic [31:0] data_in;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int bad = 0;
    int wr_count = 0;
    int consumed = 0;
    bit gap_mode = 0;
    bit phase = 0;
    bit xfer_pending = 0;
    bit prev_rw = 1;

    logic [7:0]  byte_q[$];
    logic [7:0]  pat[$];
    wr_t         exp_q[$];
    logic [31:0] mem[64];

    imem_loader #(.DEPTH_BYTES(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .load_words(load_words), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .iaddr(iaddr), .ins_mem_rw(ins_mem_rw),
        .data_in(data_in), .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit load_ok(input logic [31:0] base, input logic [7:0] n);
        longint unsigned last;
        last = longint'(base) + 4 * longint'(n);
        return (base[1:0] == 2'b00) && (last <= 256);
    endfunction

    // Byte source: a transfer seen at one negedge is retired at the next
    always @(negedge clk) begin
        if (xfer_pending && byte_q.size() > 0) begin
            void'(byte_q.pop_front());
            consumed++;
        end
        phase = !phase;
        if (byte_q.size() > 0 && (!gap_mode || phase)) begin
            byte_valid = 1'b1;
            byte_in    = byte_q[0];
        end else begin
            byte_valid = 1'b0;
            byte_in    = 8'hEE;
        end
        xfer_pending = byte_valid && byte_ready;
    end

    // Per-cycle checks of the memory port against the predicted write list
    always @(negedge clk) begin
        if (rst_n) begin
            chk("hold_eq_busy", 32'(cpu_hold), 32'(busy));
            if (!ins_mem_rw) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(ins_mem_rw), 32'd1);
                end else begin
                    chk("wr_addr", iaddr, exp_q[0].addr);
                    chk("wr_data", data_in, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                chk("rw_single_cycle", 32'(prev_rw), 32'd1);
                chk("ready_low_in_write", 32'(byte_ready), 32'd0);
                mem[iaddr[7:2]] = data_in;
                wr_count++;
            end
            if (!busy) begin
                chk("idle_ready", 32'(byte_ready), 32'd0);
                chk("idle_rw", 32'(ins_mem_rw), 32'd1);
            end
            prev_rw = ins_mem_rw;
        end
    end

    // Predict writes from the byte pattern and queue the stream (plus checksum byte)
    task automatic plan_load(input logic [31:0] base, input int n, input bit use_ck, input logic [7:0] ck);
        logic [7:0] sum;
        wr_t w;
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            w.addr = base + 32'(4 * i);
            w.data = {pat[4*i], pat[4*i+1], pat[4*i+2], pat[4*i+3]};
            exp_q.push_back(w);
            for (int k = 0; k < 4; k++) begin
                byte_q.push_back(pat[4*i+k]);
                sum = sum + pat[4*i+k];
            end
        end
        if (CK == 1) byte_q.push_back(use_ck ? ck : 8'(8'h00 - sum));
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [7:0] n);
        @(negedge clk);
        start = 1'b1; base_addr = base; load_words = n;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; base_addr = 32'hDEAD_BEEF; load_words = 8'hFF;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 1;
        while (!(done || error) && n < limit) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("finish_within_bound", 32'(done || error), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iaddr"}, iaddr, 32'd0);
        chk({tag, "_rw"}, 32'(ins_mem_rw), 32'd1);
        chk({tag, "_data"}, data_in, 32'd0);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic run_good(input string tag, input logic [31:0] base, input int n, input int cyc_exp);
        int c;
        int w0;
        w0 = wr_count;
        plan_load(base, n, 1'b0, 8'h00);
        pulse_start(base, 8'(n));
        wait_done(200, c);
        if (cyc_exp > 0) chk({tag, "_cycles"}, 32'(c), 32'(cyc_exp));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_writes"}, 32'(wr_count - w0), 32'(n));
        chk({tag, "_bytes_left"}, 32'(byte_q.size()), 32'd0);
        chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_bad(input string tag, input logic [31:0] base, input logic [7:0] n);
        int c;
        int w0;
        w0 = wr_count;
        pulse_start(base, n);
        wait_done(20, c);
        repeat (3) @(negedge clk);
        chk({tag, "_error"}, 32'(error), 32'(!load_ok(base, n)));
        chk({tag, "_error_lit"}, 32'(error), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_writes"}, 32'(wr_count - w0), 32'd0);
    endtask

    initial begin
        int c;
        int w0;
        int t;
        int c0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back stream
        pat = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_good("t1", 32'h0, 2, 12 + CK);
        chk("t1_mem0", mem[0], 32'h1234_5678);
        chk("t1_mem1", mem[1], 32'h9ABC_DEF0);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // valid toggling every other cycle
        gap_mode = 1;
        run_good("t2", 32'h20, 2, 0);
        gap_mode = 0;
        chk("t2_mem8", mem[8], 32'h1234_5678);
        chk("t2_mem9", mem[9], 32'h9ABC_DEF0);

        // rejected starts, then the exact-fit boundary
        run_bad("mis", 32'h2, 8'd1);
        run_bad("ovf", 32'hFC, 8'd2);
        run_bad("wrap", 32'hFFFF_FFFC, 8'd2);
        pat = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        run_good("edge", 32'hF8, 2, 12 + CK);
        chk("edge_mem62", mem[62], 32'hA1A2_A3A4);
        chk("edge_mem63", mem[63], 32'hB1B2_B3B4);

        // reset after byte 2 of word 1 of a 3-word load
        pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                8'h99, 8'hAA, 8'hBB, 8'hCC};
        c0 = consumed;
        plan_load(32'h40, 3, 1'b0, 8'h00);
        pulse_start(32'h40, 8'd3);
        t = 0;
        while (consumed < c0 + 6 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("abort_reached", 32'(consumed - c0), 32'd6);
        rst_n = 1'b0;
        byte_q.delete();
        exp_q.delete();
        xfer_pending = 0;
        prev_rw = 1;
        #1;
        chk_reset_vals("abort");
        chk("abort_mem16", mem[16], 32'h1122_3344);
        chk("abort_mem17", mem[17], 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_good("reload", 32'h44, 1, 7 + CK);
        chk("reload_mem17", mem[17], 32'hAABB_CCDD);
        chk("reload_mem16", mem[16], 32'h1122_3344);

        // zero-word load
        pat.delete();
        run_good("zero", 32'h80, 0, 2 + CK);

        // Start during a load must not retarget or recount it
        pat = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        w0 = wr_count;
        plan_load(32'h80, 1, 1'b0, 8'h00);
        pulse_start(32'h80, 8'd1);
        pulse_start(32'h0, 8'd5);
        wait_done(100, c);
        chk("busy_start_done", 32'(done), 32'd1);
        chk("busy_start_writes", 32'(wr_count - w0), 32'd1);
        chk("busy_start_mem32", mem[32], 32'hC0C1_C2C3);
        repeat (4) @(negedge clk);
        chk("busy_start_idle", 32'(busy), 32'd0);
        chk("busy_start_bytes", 32'(byte_q.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pat = '{8'h01, 8'h02, 8'h03, 8'h04};
        plan_load(32'h60, 1, 1'b1, 8'hF6);
        pulse_start(32'h60, 8'd1);
        wait_done(50, c);
        chk("ck_ok_done", 32'(done), 32'd1);
        chk("ck_ok_error", 32'(error), 32'd0);
        chk("ck_ok_mem", mem[24], 32'h0102_0304);
        mem[24] = 32'h0;
        plan_load(32'h60, 1, 1'b1, 8'hF7);
        pulse_start(32'h60, 8'd1);
        wait_done(50, c);
        chk("ck_bad_done", 32'(done), 32'd0);
        chk("ck_bad_error", 32'(error), 32'd1);
        chk("ck_bad_mem", mem[24], 32'h0102_0304);
        chk("ck_bad_bytes", 32'(byte_q.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
